// File: rtl/stride_prefetch_ctrl_if.sv
// Bundle of the load-commit, demand-miss and memory-port signals around the stride prefetcher.
// The master side drives loads, demands and memory completions; the slave side is the controller.
interface stride_prefetch_ctrl_if;
  logic        load_valid;
  logic [31:0] load_addr;
  logic        dmd_read;
  logic [31:0] dmd_addr;
  logic        dmd_resp;
  logic        pmem_read;
  logic [31:0] pmem_address;
  logic        pmem_resp;
  logic        pf_fill;
  logic [31:0] stride_out;
  logic [1:0]  conf_out;

  modport master (
    output load_valid, load_addr, dmd_read, dmd_addr, pmem_resp,
    input  dmd_resp, pmem_read, pmem_address, pf_fill, stride_out, conf_out
  );

  modport slave (
    input  load_valid, load_addr, dmd_read, dmd_addr, pmem_resp,
    output dmd_resp, pmem_read, pmem_address, pf_fill, stride_out, conf_out
  );
endinterface

// File: rtl/stride_prefetch_ctrl.sv
// Stride prefetcher: learns a load stride with a 2-bit confidence counter, queues line-aligned
// prefetch targets, and shares the single memory read port with demand misses (demand first).
module stride_prefetch_ctrl #(
  parameter int unsigned PF_DEPTH   = 4,
  parameter int unsigned LINE_BYTES = 32,
  parameter int unsigned PF_DIST    = 1,
  parameter int unsigned CONF_TH    = 2
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  stride_prefetch_ctrl_if.slave pf_if
);

  localparam int unsigned PTR_W     = (PF_DEPTH > 1) ? $clog2(PF_DEPTH) : 1;
  localparam int unsigned CNT_W     = $clog2(PF_DEPTH) + 1;
  localparam logic [31:0] LINE_MASK = ~(32'(LINE_BYTES) - 32'd1);
  localparam logic [31:0] DIST      = 32'(PF_DIST);
  localparam logic [1:0]  TH        = 2'(CONF_TH);

  typedef enum logic [1:0] {S_IDLE, S_DMD, S_PF} state_e;

  state_e      state_q;
  logic        pmem_read_q;
  logic [31:0] pmem_addr_q;

  logic        have_last_q, have_last_d;
  logic [31:0] last_addr_q, last_addr_d;
  logic [31:0] stride_q, stride_d;
  logic [1:0]  conf_q, conf_d;
  logic [31:0] last_push_q;

  logic [31:0]         mem_q [PF_DEPTH];
  logic [PF_DEPTH-1:0] valid_q;
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    count_q;

  logic [31:0] delta, step, cand;
  logic        gen, in_queue, full, empty, pop, push;

  assign delta = pf_if.load_addr - last_addr_q;

  always_comb begin
    have_last_d = have_last_q;
    last_addr_d = last_addr_q;
    stride_d    = stride_q;
    conf_d      = conf_q;
    gen         = 1'b0;
    if (pf_if.load_valid) begin
      have_last_d = 1'b1;
      last_addr_d = pf_if.load_addr;
      if (have_last_q) begin
        if (delta == stride_q && delta != '0) begin
          if (conf_q != 2'd3) conf_d = conf_q + 2'd1;
        end else if (conf_q != '0) begin
          conf_d = conf_q - 2'd1;
        end else begin
          stride_d = delta;
        end
        gen = (conf_d >= TH);
      end
    end
  end

  // Target uses the stride as updated by this same load.
  assign step = stride_d * DIST;
  assign cand = (pf_if.load_addr + step) & LINE_MASK;

  always_comb begin
    in_queue = 1'b0;
    for (int unsigned i = 0; i < PF_DEPTH; i++) begin
      if (valid_q[i] && mem_q[i] == cand) in_queue = 1'b1;
    end
  end

  assign full  = (count_q == CNT_W'(PF_DEPTH));
  assign empty = (count_q == '0);
  assign pop   = (state_q == S_IDLE) && !pf_if.dmd_read && !empty;
  assign push  = gen && (cand != last_push_q) && !(pf_if.dmd_read && cand == pf_if.dmd_addr)
                 && !in_queue && (!full || pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      have_last_q <= 1'b0;
      last_addr_q <= '0;
      stride_q    <= '0;
      conf_q      <= '0;
      last_push_q <= '0;
    end else begin
      have_last_q <= have_last_d;
      last_addr_q <= last_addr_d;
      stride_q    <= stride_d;
      conf_q      <= conf_d;
      if (push) last_push_q <= cand;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= cand;
  end

  // Pop clears before push sets, so a full queue can pop and push into the same slot.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (pop) begin
        valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q          <= rd_ptr_q + PTR_W'(1);
      end
      if (push) begin
        valid_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
      end
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      pmem_read_q <= 1'b0;
      pmem_addr_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pf_if.dmd_read) begin
            state_q     <= S_DMD;
            pmem_addr_q <= pf_if.dmd_addr;
            pmem_read_q <= 1'b1;
          end else if (!empty) begin
            state_q     <= S_PF;
            pmem_addr_q <= mem_q[rd_ptr_q];
            pmem_read_q <= 1'b1;
          end
        end
        S_DMD, S_PF: begin
          if (pf_if.pmem_resp) begin
            state_q     <= S_IDLE;
            pmem_read_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          pmem_read_q <= 1'b0;
        end
      endcase
    end
  end

  assign pf_if.dmd_resp     = (state_q == S_DMD) && pf_if.pmem_resp;
  assign pf_if.pf_fill      = (state_q == S_PF) && pf_if.pmem_resp;
  assign pf_if.pmem_read    = pmem_read_q;
  assign pf_if.pmem_address = pmem_addr_q;
  assign pf_if.stride_out   = stride_q;
  assign pf_if.conf_out     = conf_q;

endmodule

// File: tb/tb_stride_prefetch_ctrl.sv
// Directed bench for stride_prefetch_ctrl with hand-computed expectations.
module tb_stride_prefetch_ctrl;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  stride_prefetch_ctrl_if bus();

  stride_prefetch_ctrl #(
    .PF_DEPTH(4),
    .LINE_BYTES(32),
    .PF_DIST(1),
    .CONF_TH(2)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .pf_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [31:0] a, input logic [1:0] exp_conf, input logic [31:0] exp_stride);
    bus.load_valid = 1'b1;
    bus.load_addr  = a;
    tick();
    bus.load_valid = 1'b0;
    chk($sformatf("conf@%h", a), 32'(bus.conf_out), 32'(exp_conf));
    chk($sformatf("stride@%h", a), bus.stride_out, exp_stride);
  endtask

  task automatic resp_pf(input string tag);
    bus.pmem_resp = 1'b1;
    #1;
    chk({tag, "_pf_fill"}, 32'(bus.pf_fill), 32'd1);
    chk({tag, "_no_dmd_resp"}, 32'(bus.dmd_resp), 32'd0);
    tick();
    bus.pmem_resp = 1'b0;
    chk({tag, "_rd_drop"}, 32'(bus.pmem_read), 32'd0);
  endtask

  task automatic resp_dmd(input string tag);
    bus.pmem_resp = 1'b1;
    #1;
    chk({tag, "_dmd_resp"}, 32'(bus.dmd_resp), 32'd1);
    chk({tag, "_no_pf_fill"}, 32'(bus.pf_fill), 32'd0);
    tick();
    bus.pmem_resp = 1'b0;
    bus.dmd_read  = 1'b0;
    chk({tag, "_rd_drop"}, 32'(bus.pmem_read), 32'd0);
  endtask

  task automatic expect_issue(input string tag, input logic [31:0] addr);
    int n = 0;
    while (!bus.pmem_read && n < 8) begin
      tick();
      n++;
    end
    chk({tag, "_rd"}, 32'(bus.pmem_read), 32'd1);
    chk({tag, "_addr"}, bus.pmem_address, addr);
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_addr  = '0;
    bus.dmd_read   = 1'b0;
    bus.dmd_addr   = '0;
    bus.pmem_resp  = 1'b0;
    tick();
    tick();
    chk("rst_pmem_read", 32'(bus.pmem_read), 32'd0);
    chk("rst_pmem_addr", bus.pmem_address, 32'd0);
    chk("rst_stride", bus.stride_out, 32'd0);
    chk("rst_conf", 32'(bus.conf_out), 32'd0);
    chk("rst_dmd_resp", 32'(bus.dmd_resp), 32'd0);
    chk("rst_pf_fill", 32'(bus.pf_fill), 32'd0);
    rst_n = 1'b1;
    tick();

    // Stride learning and first prefetches
    load(32'h0E0, 2'd0, 32'h0);
    load(32'h100, 2'd0, 32'h20);
    load(32'h120, 2'd1, 32'h20);
    chk("t1_no_req_yet", 32'(bus.pmem_read), 32'd0);
    load(32'h140, 2'd2, 32'h20);
    load(32'h160, 2'd3, 32'h20);
    chk("t1_first_rd", 32'(bus.pmem_read), 32'd1);
    chk("t1_first_addr", bus.pmem_address, 32'h160);
    resp_pf("t1_a");
    tick();
    chk("t1_second_rd", 32'(bus.pmem_read), 32'd1);
    chk("t1_second_addr", bus.pmem_address, 32'h180);
    resp_pf("t1_b");
    tick();
    chk("t1_drained", 32'(bus.pmem_read), 32'd0);

    // Stride break: confidence decays before the stride is replaced
    load(32'h168, 2'd2, 32'h20);
    tick();
    chk("t2_last_push_dup", 32'(bus.pmem_read), 32'd0);
    load(32'h170, 2'd1, 32'h20);
    load(32'h178, 2'd0, 32'h20);
    load(32'h180, 2'd0, 32'h8);

    // Demand and prefetch collide in IDLE
    load(32'h188, 2'd1, 32'h8);
    load(32'h190, 2'd2, 32'h8);
    load(32'h198, 2'd3, 32'h8);
    bus.dmd_read = 1'b1;
    bus.dmd_addr = 32'h400;
    tick();
    chk("t3_dmd_rd", 32'(bus.pmem_read), 32'd1);
    chk("t3_dmd_addr", bus.pmem_address, 32'h400);
    resp_dmd("t3_dmd");
    tick();
    chk("t3_pf_rd", 32'(bus.pmem_read), 32'd1);
    chk("t3_pf_addr", bus.pmem_address, 32'h1A0);
    resp_pf("t3_pf");
    tick();

    // Demand arrives during an in-flight prefetch
    load(32'h1B8, 2'd2, 32'h8);
    load(32'h1C0, 2'd3, 32'h8);
    chk("t4_pf_addr", bus.pmem_address, 32'h1C0);
    load(32'h1C8, 2'd3, 32'h8);
    load(32'h1D0, 2'd3, 32'h8);
    load(32'h1D8, 2'd3, 32'h8);
    bus.dmd_read = 1'b1;
    bus.dmd_addr = 32'h800;
    tick();
    chk("t4_hold_addr1", bus.pmem_address, 32'h1C0);
    tick();
    chk("t4_hold_addr2", bus.pmem_address, 32'h1C0);
    chk("t4_hold_rd", 32'(bus.pmem_read), 32'd1);
    resp_pf("t4_pf");
    tick();
    chk("t4_dmd_addr", bus.pmem_address, 32'h800);
    resp_dmd("t4_dmd");
    tick();
    chk("t4_next_pf_addr", bus.pmem_address, 32'h1E0);
    resp_pf("t4_pf2");
    tick();

    // Asynchronous reset in the middle of a demand
    bus.dmd_read = 1'b1;
    bus.dmd_addr = 32'hA00;
    tick();
    chk("t6_dmd_rd", 32'(bus.pmem_read), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_rd", 32'(bus.pmem_read), 32'd0);
    chk("t6_async_addr", bus.pmem_address, 32'd0);
    chk("t6_async_conf", 32'(bus.conf_out), 32'd0);
    chk("t6_async_stride", bus.stride_out, 32'd0);
    bus.dmd_read = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.pmem_resp = 1'b1;
    #1;
    chk("t6_no_dmd_resp", 32'(bus.dmd_resp), 32'd0);
    chk("t6_no_pf_fill", 32'(bus.pf_fill), 32'd0);
    tick();
    bus.pmem_resp = 1'b0;
    tick();
    chk("t6_idle_rd", 32'(bus.pmem_read), 32'd0);

    // Full queue with the port held by a stalled demand
    bus.dmd_read = 1'b1;
    bus.dmd_addr = 32'h0FA0;
    tick();
    chk("t5_dmd_addr", bus.pmem_address, 32'h0FA0);
    load(32'h0F00, 2'd0, 32'h0);
    load(32'h0F20, 2'd0, 32'h20);
    load(32'h0F40, 2'd1, 32'h20);
    load(32'h0F60, 2'd2, 32'h20);
    load(32'h0F80, 2'd3, 32'h20);
    load(32'h0FA0, 2'd3, 32'h20);
    load(32'h0F60, 2'd2, 32'h20);
    load(32'h0F80, 2'd3, 32'h20);
    load(32'h0FA0, 2'd3, 32'h20);
    load(32'h0FC0, 2'd3, 32'h20);
    load(32'h0FE0, 2'd3, 32'h20);
    load(32'h1000, 2'd3, 32'h20);
    chk("t5_still_dmd", bus.pmem_address, 32'h0FA0);
    resp_dmd("t5_dmd");
    expect_issue("t5_q0", 32'h0F80);
    resp_pf("t5_q0");
    expect_issue("t5_q1", 32'h0FC0);
    resp_pf("t5_q1");
    expect_issue("t5_q2", 32'h0FE0);
    resp_pf("t5_q2");
    expect_issue("t5_q3", 32'h1000);
    resp_pf("t5_q3");
    tick();
    tick();
    tick();
    chk("t5_fifth_dropped", 32'(bus.pmem_read), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
